// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - exhaustive 3-input OR sweep comparing two result ports
// Walks idx 000..111 on {vec_a,vec_b,vec_c}, settles, then scores both returned results.
module gate_vector_checker #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       vec_a,
   output logic       vec_b,
   output logic       vec_c,
   input  logic       res_3in,
   input  logic       res_inst,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] mismatch_cnt,
   output logic       fail_3in,
   output logic       fail_inst,
   output logic [2:0] first_fail_idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [2:0] idx;
   logic [3:0] settle_cnt;
   logic       exp_or;
   logic       bad_3in;
   logic       bad_inst;

   // Expected value is taken from the registered vector actually on the wires.
   assign exp_or   = vec_a | vec_b | vec_c;
   assign bad_3in  = (res_3in  != exp_or);
   assign bad_inst = (res_inst != exp_or);

   assign pass = done & (mismatch_cnt == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= 3'd0;
         settle_cnt     <= 4'd0;
         vec_a          <= 1'b0;
         vec_b          <= 1'b0;
         vec_c          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         mismatch_cnt   <= 4'd0;
         fail_3in       <= 1'b0;
         fail_inst      <= 1'b0;
         first_fail_idx <= 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state                 <= APPLY;
                  idx                   <= 3'd0;
                  settle_cnt            <= 4'd0;
                  {vec_a, vec_b, vec_c} <= 3'd0;
                  busy                  <= 1'b1;
                  done                  <= 1'b0;
                  mismatch_cnt          <= 4'd0;
                  fail_3in              <= 1'b0;
                  fail_inst             <= 1'b0;
                  first_fail_idx        <= 3'd0;
               end
            end

            APPLY: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end

            CHECK: begin
               if (bad_3in || bad_inst) begin
                  mismatch_cnt <= mismatch_cnt + 4'd1;
                  if (mismatch_cnt == 4'd0) begin
                     first_fail_idx <= idx;
                  end
               end
               if (bad_3in) begin
                  fail_3in <= 1'b1;
               end
               if (bad_inst) begin
                  fail_inst <= 1'b1;
               end
               settle_cnt <= 4'd0;
               // Last vector stays on the outputs through DONE.
               if (idx == 3'd7) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state                 <= APPLY;
                  idx                   <= idx + 3'd1;
                  {vec_a, vec_b, vec_c} <= idx + 3'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
